// File: rtl/mdclcg_word_collector_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdclcg_word_collector_if : bit-in / word-out bundle for collector   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface mdclcg_word_collector_if #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              bit_in;
  logic              bit_valid;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              run_err;

  modport master (
    output bit_in, bit_valid, word_ready,
    input  word_out, word_valid, level, overflow, run_err
  );

  modport slave (
    input  bit_in, bit_valid, word_ready,
    output word_out, word_valid, level, overflow, run_err
  );
endinterface
`default_nettype wire

// File: rtl/mdclcg_word_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdclcg_word_collector : packs serial Zi bits MSB-first into words,  |
// | queues them in a FWFT FIFO and runs a repetition-count check. R1.0  |
// +--------------------------------------------------------------------+
module mdclcg_word_collector #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RUN_LIMIT  = 34
) (
  input  logic                  clk,
  input  logic                  start,
  mdclcg_word_collector_if.slave bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(WORD_W);
  localparam int RUN_W = $clog2(RUN_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_LIMIT);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              last_q, last_d;
  logic              rerr_q, rerr_d;
  logic              ovf_q, ovf_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;

  logic              w_done;
  logic [WORD_W-1:0] w_word;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;

  assign w_word  = {sr_q[WORD_W-2:0], bus.bit_in};
  assign w_done  = bus.bit_valid && (cnt_q == CNT_LAST);
  assign w_valid = (lvl_q != '0);
  assign w_pop   = w_valid && bus.word_ready;
  // A full FIFO still takes the new word when the head leaves on the same edge.
  assign w_push  = w_done && ((lvl_q != LVL_FULL) || w_pop);

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    last_d = last_q;
    rerr_d = rerr_q;
    if (bus.bit_valid) begin
      sr_d   = w_word;
      cnt_d  = w_done ? '0 : cnt_q + 1'b1;
      last_d = bus.bit_in;
      // run_q == 0 only before the first bit after reset, so that bit starts a fresh run.
      if ((run_q != '0) && (bus.bit_in == last_q)) begin
        if (run_q != RUN_MAX) run_d = run_q + 1'b1;
      end else begin
        run_d = RUN_W'(1);
      end
      if (run_d == RUN_MAX) rerr_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    ovf_d    = ovf_q | (w_done & ~w_push);
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      run_q    <= '0;
      last_q   <= 1'b0;
      rerr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      last_q   <= last_d;
      rerr_q   <= rerr_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
      if (w_push) mem_q[wr_ptr_q] <= w_word;
    end
  end

  assign bus.word_out   = mem_q[rd_ptr_q];
  assign bus.word_valid = w_valid;
  assign bus.level      = lvl_q;
  assign bus.overflow   = ovf_q;
  assign bus.run_err    = rerr_q;
endmodule
`default_nettype wire

// File: doc/mdclcg_word_collector.md
# mdclcg_word_collector

Receive-side companion to the modified dual-CLCG generator: consumes its serial pseudo-random bit stream (Zi) and packs it MSB-first into WORD_W-bit words. Words are queued in a small FIFO and drained through a valid/ready handshake. The block also runs a repetition-count health check on the incoming bits and reports sticky error flags. It sits between the MDCLCG core and any word-wide consumer (bus interface, test logger).

## Interface
- WORD_W, 32, bits per packed word (≥2).
- FIFO_DEPTH, 4, word FIFO entries (power of 2, ≥2).
- RUN_LIMIT, 34, consecutive identical accepted bits that trip run_err (≥2).
- LVL_W, $clog2(FIFO_DEPTH)+1, width of level (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- start  in  1  reset: synchronous, active-high.
- bit_in  in  1  serial random bit (generator Zi).
- bit_valid  in  1  bit_in is accepted on this edge when high.
- word_out  out  WORD_W  FIFO head word.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts head when word_valid && word_ready.
- level  out  LVL_W  words currently in FIFO.
- overflow  out  1  sticky: a completed word was dropped.
- run_err  out  1  sticky: repetition run reached RUN_LIMIT.

## Operation
- Reset (start=1 at an edge): shift register, bit count, run counter, last-bit, FIFO pointers and storage cleared. Outputs after reset: word_out=0, word_valid=0, level=0, overflow=0, run_err=0. bit_valid and word_ready ignored while start=1. Reset mid-word discards partial bits.
- Accept: on edge with bit_valid=1, sr <= {sr[WORD_W-2:0], bit_in}; cnt increments. First accepted bit of a word ends in bit WORD_W-1.
- Word completion: the edge accepting the WORD_W-th bit forms {sr[WORD_W-2:0], bit_in} and pushes it to the FIFO on that same edge; cnt returns to 0. No accept-stall: input is never backpressured.
- Push rule: push succeeds if FIFO not full, or if a pop occurs on the same edge. Otherwise the word is discarded, overflow set to 1, cnt still returns to 0.
- Pop: word_valid && word_ready at edge removes head. Pop on empty impossible (word_valid=0).
- Simultaneous push+pop: level unchanged; ordering preserved (pushed word behind all older words).
- FIFO: first-word-fall-through; word_out shows head whenever word_valid=1; pointers wrap modulo FIFO_DEPTH.
- Run check: on each accepted bit, if bit_in equals last bit run <= run+1 else run <= 1; first bit after reset gives run=1. run saturates at RUN_LIMIT. run_err set on the edge where run becomes RUN_LIMIT; cleared only by start. Run tracking spans word boundaries.
- Sticky flags never self-clear; they do not block operation.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Word latency: WORD_W-th bit accepted at edge k → word_valid=1 and word_out valid in cycle following edge k (when FIFO was empty).
- Pop at edge k → next entry (or word_valid=0) visible after edge k.
- level updates on the same edge as push/pop.
- bit_valid gaps of any length allowed; only accepted bits count.
- Throughput: one bit per cycle in; one word per cycle out.
- overflow/run_err assert in the cycle after the triggering edge.

## Test plan
- Reset: hold start=1 for 2 cycles with bit_valid=1 → word_out=0, word_valid=0, level=0, overflow=0, run_err=0.
- Pack: word_ready=1, feed 0xA5A5A5A5 MSB-first with random bit_valid gaps → exactly one word 0xA5A5A5A5, word_valid high for one cycle, level returns to 0.
- Overflow: word_ready=0, feed 5 words 0x00000001..0x00000005 → level=4, overflow=1; then drain → 1,2,3,4 in order, word 5 lost.
- Full + simultaneous pop: FIFO full, word_ready=1 on edge of 32nd bit of 0xDEADBEEF → overflow stays 0, level stays 4, 0xDEADBEEF last out.
- Run check: 33 ones then a 0 → run_err=0; after reset, 34 ones → run_err=1 after 34th accept, stays 1 with further alternating bits.
- Reset mid-word: 17 bits accepted, start pulse, then 0x12345678 → only word out is 0x12345678.
